// File: rtl/rs_pkg.sv
// Shared definitions for the RS-latch pulse front-end: FSM encoding, request
// indices and default parameter values.
package rs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        CLR_P = 2'd2,
        GAP   = 2'd3
    } rs_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_CYC     = 4;
    localparam int DEF_PW_CYC      = 3;
    localparam int DEF_GAP_CYC     = 2;
    localparam int DEF_CNT_W       = 8;

    // Request channel indices into the per-channel vectors of the top level.
    localparam int REQ_SET = 0;
    localparam int REQ_CLR = 1;
    localparam int REQ_NUM = 2;

endpackage

// File: rtl/rs_deb.sv
// Synchroniser, debounce filter and rising-edge detector for one asynchronous
// request level; rise is a one-cycle registered pulse on each accepted 0->1.
module rs_deb
    import rs_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYC     = DEF_DEB_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic rise
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   level_reg;
    logic                   level_next;
    logic                   rise_reg;
    logic                   rise_next;
    logic                   sample;

    assign sample = sync_reg[SYNC_STAGES-1];
    assign rise   = rise_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], req};
        end
    end

    // The counter only advances over an unbroken run of samples that disagree
    // with the accepted level; any agreeing sample restarts the run.
    always_comb begin
        cnt_next   = cnt_reg;
        level_next = level_reg;
        rise_next  = 1'b0;
        if (sample != level_reg) begin
            if (cnt_reg == DEB_LAST) begin
                level_next = ~level_reg;
                rise_next  = ~level_reg;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg + CNT_ONE;
            end
        end else begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
        end
    end

endmodule

// File: rtl/rs_pulse_gen.sv
// Drives the active-low sn/rn inputs of a NAND RS latch with fixed-width,
// mutually exclusive pulses separated by a guard gap.
module rs_pulse_gen
    import rs_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYC     = DEF_DEB_CYC,
    parameter int PW_CYC      = DEF_PW_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    output logic sn,
    output logic rn,
    output logic busy,
    output logic ovf
);

    localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PW_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [REQ_NUM-1:0] req_vec;
    logic [REQ_NUM-1:0] rise_vec;
    logic [REQ_NUM-1:0] pend_reg;
    logic [REQ_NUM-1:0] pend_next;
    logic [REQ_NUM-1:0] take;

    rs_state_t        state_reg;
    rs_state_t        state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic             sn_reg;
    logic             sn_next;
    logic             rn_reg;
    logic             rn_next;
    logic             busy_reg;
    logic             busy_next;

    assign req_vec[REQ_SET] = set_req;
    assign req_vec[REQ_CLR] = clr_req;

    generate
        for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_deb
            rs_deb #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEB_CYC     (DEB_CYC),
                .CNT_W       (CNT_W)
            ) u_deb (
                .clk   (clk),
                .rst_n (rst_n),
                .req   (req_vec[gi]),
                .rise  (rise_vec[gi])
            );
        end
    endgenerate

    // Clear wins over set when both are waiting, so the latch settles reset.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        take       = '0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (pend_reg[REQ_CLR]) begin
                    state_next    = CLR_P;
                    take[REQ_CLR] = 1'b1;
                end else if (pend_reg[REQ_SET]) begin
                    state_next    = SET_P;
                    take[REQ_SET] = 1'b1;
                end
            end
            SET_P, CLR_P: begin
                if (cnt_reg == PW_LAST) begin
                    state_next = GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // A flag consumed this cycle is free to accept a new edge without loss.
    always_comb begin
        pend_next = (pend_reg & ~take) | rise_vec;
        ovf_next  = ovf_reg | (|(rise_vec & pend_reg & ~take));
        sn_next   = (state_next != SET_P);
        rn_next   = (state_next != CLR_P);
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            pend_reg  <= '0;
            ovf_reg   <= 1'b0;
            sn_reg    <= 1'b1;
            rn_reg    <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
            ovf_reg   <= ovf_next;
            sn_reg    <= sn_next;
            rn_reg    <= rn_next;
            busy_reg  <= busy_next;
        end
    end

    assign sn   = sn_reg;
    assign rn   = rn_reg;
    assign busy = busy_reg;
    assign ovf  = ovf_reg;

endmodule
